// File: rtl/dma_pkg.sv
// dma_pkg: shared scheduler state encoding and width defaults
// for the DMA channel scheduler slice.
package dma_pkg;

    localparam int AW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_BSY = 2'd2,
        RUN      = 2'd3
    } state_t;

endpackage

// File: rtl/dma_rr_pick.sv
// dma_rr_pick: combinational round-robin picker, first requester
// at or after ptr wins, wrapping from NCH-1 back to 0.
module dma_rr_pick #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [NCH-1:0]         onehot,
    output logic [$clog2(NCH)-1:0] idx,
    output logic                   valid
);

    localparam int IW = $clog2(NCH);

    logic [IW-1:0] j;

    // Scan from farthest to nearest so the nearest hit is kept.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NCH);
            if (req[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = j;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_ch_sched.sv
// dma_ch_sched: round-robin owner of the shared DMA engine.
// Define DMA_SCHED_WDT_EN to enable the engine watchdog (WDT_MAX cycles).
module dma_ch_sched
    import dma_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int AW      = AW_DEF,
    parameter int WDT_MAX = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH*AW-1:0]      ch_src,
    input  logic [NCH*AW-1:0]      ch_dst,
    input  logic [NCH*AW-1:0]      ch_size,
    output logic [NCH-1:0]         ch_ack,
    output logic [NCH-1:0]         ch_done,
    output logic [NCH-1:0]         ch_err,
    output logic                   eng_start,
    output logic [AW-1:0]          eng_src,
    output logic [AW-1:0]          eng_dst,
    output logic [AW-1:0]          eng_size,
    input  logic                   eng_busy,
    output logic [$clog2(NCH)-1:0] grant_id,
    output logic                   sched_busy
);

    localparam int IW = $clog2(NCH);

    state_t         state;
    state_t         state_nx;
    logic [IW-1:0]  rr;
    logic [IW-1:0]  pick_idx;
    logic [NCH-1:0] pick_oh;
    logic           pick_vld;
    logic           wdt_hit;
    logic           take;
    logic           zero_len;
    logic           finish;
    logic           watching;
    logic           start_nx;
    logic [NCH-1:0] ack_nx;
    logic [NCH-1:0] done_nx;
    logic [NCH-1:0] err_nx;

    dma_rr_pick #(
        .NCH(NCH)
    ) u_pick (
        .req   (ch_req),
        .ptr   (rr),
        .onehot(pick_oh),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (pick_vld) state_nx = LAUNCH;
            LAUNCH:   state_nx = (eng_size == '0) ? IDLE : WAIT_BSY;
            WAIT_BSY: if (eng_busy || wdt_hit) state_nx = eng_busy ? RUN : IDLE;
            RUN:      if (!eng_busy || wdt_hit) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Pulses are computed here and registered below, so every output is a flop.
    always_comb begin
        take     = (state == IDLE) && pick_vld;
        zero_len = (eng_size == '0);
        finish   = ((state == LAUNCH) && zero_len) || ((state == RUN) && !eng_busy);
        watching = ((state == WAIT_BSY) && !eng_busy) || ((state == RUN) && eng_busy);
        ack_nx   = take ? pick_oh : '0;
        start_nx = (state == LAUNCH) && !zero_len;
        done_nx  = '0;
        err_nx   = '0;
        if (finish) done_nx[grant_id] = 1'b1;
        if (watching && wdt_hit) err_nx[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr        <= '0;
            grant_id  <= '0;
            eng_src   <= '0;
            eng_dst   <= '0;
            eng_size  <= '0;
            ch_ack    <= '0;
            ch_done   <= '0;
            ch_err    <= '0;
            eng_start <= 1'b0;
        end else begin
            ch_ack    <= ack_nx;
            ch_done   <= done_nx;
            ch_err    <= err_nx;
            eng_start <= start_nx;
            if (take) begin
                eng_src  <= ch_src[int'(pick_idx)*AW +: AW];
                eng_dst  <= ch_dst[int'(pick_idx)*AW +: AW];
                eng_size <= ch_size[int'(pick_idx)*AW +: AW];
                grant_id <= pick_idx;
                rr       <= (pick_idx == IW'(NCH - 1)) ? '0 : pick_idx + IW'(1);
            end
        end
    end

    assign sched_busy = (state != IDLE);

`ifdef DMA_SCHED_WDT_EN
    localparam int WW = $clog2(WDT_MAX + 1);

    logic [WW-1:0] wdt;

    assign wdt_hit = (wdt == WW'(WDT_MAX - 1));

    // Restarts on every state change, so WAIT_BSY and RUN each get a full budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      wdt <= '0;
        else if (state_nx != state)                    wdt <= '0;
        else if ((state == WAIT_BSY) || (state == RUN)) wdt <= wdt + WW'(1);
    end
`else
    logic unused_wdt;

    assign wdt_hit    = 1'b0;
    assign unused_wdt = (WDT_MAX != 0);
`endif

endmodule

// File: tb/tb_dma_ch_sched.sv
// tb_dma_ch_sched: directed and randomized checks of dma_ch_sched
// against a transaction-level model of the scheduling rules.
module tb_dma_ch_sched;

    localparam int NCH  = 4;
    localparam int AW   = 32;
    localparam int WMAX = 16;
`ifdef DMA_SCHED_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    localparam int P_FREE   = 0;
    localparam int P_ACKED  = 1;
    localparam int P_ENGINE = 2;
    localparam int P_MOVING = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH-1:0]    ch_req = '0;
    logic [NCH*AW-1:0] ch_src = '0;
    logic [NCH*AW-1:0] ch_dst = '0;
    logic [NCH*AW-1:0] ch_size = '0;
    logic [NCH-1:0]    ch_ack;
    logic [NCH-1:0]    ch_done;
    logic [NCH-1:0]    ch_err;
    logic              eng_start;
    logic [AW-1:0]     eng_src;
    logic [AW-1:0]     eng_dst;
    logic [AW-1:0]     eng_size;
    logic              eng_busy = 1'b0;
    logic [1:0]        grant_id;
    logic              sched_busy;

    dma_ch_sched #(
        .NCH(NCH),
        .AW(AW),
        .WDT_MAX(WMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_req    (ch_req),
        .ch_src    (ch_src),
        .ch_dst    (ch_dst),
        .ch_size   (ch_size),
        .ch_ack    (ch_ack),
        .ch_done   (ch_done),
        .ch_err    (ch_err),
        .eng_start (eng_start),
        .eng_src   (eng_src),
        .eng_dst   (eng_dst),
        .eng_size  (eng_size),
        .eng_busy  (eng_busy),
        .grant_id  (grant_id),
        .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int grant_log[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one transfer in flight, pointer after last winner.
    int             ph;
    int             m_g;
    int             m_rr;
    int             m_wdt;
    logic [NCH-1:0] e_ack;
    logic [NCH-1:0] e_done;
    logic [NCH-1:0] e_err;
    logic           e_start;
    logic [AW-1:0]  e_src;
    logic [AW-1:0]  e_dst;
    logic [AW-1:0]  e_size;

    task automatic model_reset();
        ph = P_FREE; m_g = 0; m_rr = 0; m_wdt = 0;
        e_ack = '0; e_done = '0; e_err = '0; e_start = 1'b0;
        e_src = '0; e_dst = '0; e_size = '0;
    endtask

    task automatic wdt_tick();
        if (WDT_ON && m_wdt == WMAX - 1) begin
            e_err[m_g] = 1'b1;
            ph = P_FREE;
        end else begin
            m_wdt++;
        end
    endtask

    task automatic model_step(input logic [NCH-1:0] req, input logic busy);
        bit found;
        int c;
        e_ack = '0; e_done = '0; e_err = '0; e_start = 1'b0;
        case (ph)
            P_FREE: if (req != '0) begin
                found = 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    c = (m_rr + k) % NCH;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        m_g = c;
                    end
                end
                e_ack[m_g] = 1'b1;
                e_src  = ch_src[m_g*AW +: AW];
                e_dst  = ch_dst[m_g*AW +: AW];
                e_size = ch_size[m_g*AW +: AW];
                m_rr   = (m_g + 1) % NCH;
                ph     = P_ACKED;
            end
            P_ACKED: if (e_size == 0) begin
                e_done[m_g] = 1'b1;
                ph = P_FREE;
            end else begin
                e_start = 1'b1;
                m_wdt = 0;
                ph = P_ENGINE;
            end
            P_ENGINE: if (busy) begin
                m_wdt = 0;
                ph = P_MOVING;
            end else wdt_tick();
            default: if (!busy) begin
                e_done[m_g] = 1'b1;
                ph = P_FREE;
            end else wdt_tick();
        endcase
    endtask

    always @(posedge clk) begin
        if (!rst) model_reset();
        else      model_step(ch_req, eng_busy);
        #1;
        if (rst) begin
            chk("ack", ch_ack, e_ack);
            chk("done", ch_done, e_done);
            chk("err", ch_err, e_err);
            chk("start", eng_start, e_start);
            chk("sched_busy", sched_busy, ph != P_FREE);
            chk("grant_id", grant_id, m_g[1:0]);
            chk("desc", {eng_src, eng_dst, eng_size}, {e_src, e_dst, e_size});
        end
    end

    // Engine: busy after 1..4 cycles, holds 1..8 cycles unless stuck.
    bit eng_stuck = 1'b0;
    bit eng_pend  = 1'b0;
    int eng_dly;
    int eng_len;

    always @(negedge clk) begin
        if (!rst) begin
            eng_busy = 1'b0;
            eng_pend = 1'b0;
        end else begin
            if (eng_busy) begin
                if (!eng_stuck) begin
                    if (eng_len <= 1) eng_busy = 1'b0;
                    else eng_len--;
                end
            end else if (eng_pend) begin
                if (eng_dly == 0) begin
                    eng_busy = 1'b1;
                    eng_pend = 1'b0;
                    eng_len  = $urandom_range(1, 8);
                end else eng_dly--;
            end
            if (eng_start) begin
                eng_pend = 1'b1;
                eng_dly  = $urandom_range(0, 3);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NCH; i++)
            if (ch_ack[i]) grant_log.push_back(i);
        ch_req = ch_req & ~ch_ack;
    endtask

    task automatic set_desc(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [AW-1:0] z);
        ch_src[ch*AW +: AW]  = s;
        ch_dst[ch*AW +: AW]  = d;
        ch_size[ch*AW +: AW] = z;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((ch_req != '0 || sched_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", (ch_req == '0) && !sched_busy, 1'b1);
    endtask

    task automatic wait_for(input string name, input int budget, input bit want_busy);
        int n = 0;
        while (!((want_busy && eng_busy) || (!want_busy && ch_ack != '0)) && n < budget) begin
            tick();
            n++;
        end
        chk(name, n < budget, 1'b1);
    endtask

    int fair_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_outs", {ch_ack, ch_done, ch_err, eng_start, sched_busy, grant_id},
            '0);
        chk("rst_desc", {eng_src, eng_dst, eng_size}, '0);
        rst = 1'b1;
        tick();

        // Single transfer on channel 2.
        set_desc(2, 32'h1000_0200, 32'h2000_0200, 32'd8);
        ch_req = 4'b0100;
        tick();
        chk("single_ack", ch_ack, 4'b0100);
        chk("single_src", eng_src, 32'h1000_0200);
        chk("single_dst", eng_dst, 32'h2000_0200);
        chk("single_gid", grant_id, 2'd2);
        tick();
        chk("single_start", eng_start, 1'b1);
        n = 0;
        while (ch_done == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("single_done", ch_done, 4'b0100);

        // Fairness from a fresh pointer.
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) set_desc(i, 32'h100 * i, 32'h200 * i, 32'd2 + i);
        grant_log.delete();
        ch_req = 4'b1111;
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            tick();
            for (int i = 0; i < NCH; i++)
                if (ch_done[i]) ch_req[i] = 1'b1;
            n++;
        end
        drain(200);
        for (int i = 0; i < 5; i++)
            chk("fair_order", (i < grant_log.size()) ? grant_log[i] : -1, fair_exp[i]);

        // Wrap: pointer lands on 3 after a channel-2 grant.
        ch_req = 4'b0100;
        drain(60);
        ch_req = 4'b0011;
        tick();
        chk("wrap_first", ch_ack, 4'b0001);
        tick();
        wait_for("wrap_timeout", 60, 1'b0);
        chk("wrap_second", ch_ack, 4'b0010);
        drain(60);

        // Zero-size descriptor bypasses the engine.
        set_desc(1, 32'hAAAA_0000, 32'hBBBB_0000, 32'd0);
        ch_req = 4'b0010;
        tick();
        chk("zero_ack", ch_ack, 4'b0010);
        tick();
        chk("zero_done", ch_done, 4'b0010);
        chk("zero_nostart", eng_start, 1'b0);
        chk("zero_idle", sched_busy, 1'b0);

        // Reset while the engine is running.
        eng_stuck = 1'b1;
        set_desc(3, 32'h3000_0000, 32'h4000_0000, 32'd5);
        ch_req = 4'b1000;
        wait_for("mid_timeout", 20, 1'b1);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("mid_outs", {ch_ack, ch_done, ch_err, eng_start, sched_busy, grant_id}, '0);
        chk("mid_desc", {eng_src, eng_dst, eng_size}, '0);
        @(posedge clk);
        #1 chk("mid_nodone", ch_done, '0);
        tick();
        eng_stuck = 1'b0;
        rst = 1'b1;
        set_desc(1, 32'h5, 32'h6, 32'd3);
        set_desc(2, 32'h7, 32'h8, 32'd3);
        ch_req = 4'b0110;
        tick();
        chk("mid_regrant", ch_ack, 4'b0010);
        drain(80);

`ifdef DMA_SCHED_WDT_EN
        eng_stuck = 1'b1;
        set_desc(0, 32'h9, 32'hA, 32'd4);
        ch_req = 4'b0001;
        wait_for("wdt_timeout", 20, 1'b1);
        tick();
        repeat (WMAX) tick();
        chk("wdt_err", ch_err, 4'b0001);
        chk("wdt_idle", sched_busy, 1'b0);
        eng_stuck = 1'b0;
        repeat (12) tick();
        drain(40);
`endif

        // Randomized traffic with zero sizes and dropped requests.
        for (int t = 0; t < 600; t++) begin
            tick();
            for (int i = 0; i < NCH; i++) begin
                if (!ch_req[i] && $urandom_range(0, 5) == 0) begin
                    set_desc(i, $urandom, $urandom,
                             ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 64)));
                    ch_req[i] = 1'b1;
                end else if (ch_req[i] && $urandom_range(0, 39) == 0) begin
                    ch_req[i] = 1'b0;
                end
            end
        end
        drain(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
